// File: rtl/decode_stage.sv
// rv32i decode / operand-read stage: decodes one instruction per cycle, reads the
// register file with write-back bypass, and stalls RAW/WAW hazards on a busy scoreboard.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_illegal
);
  localparam logic [6:0] OP_R    = 7'b0110011, OP_I   = 7'b0010011, OP_LD  = 7'b0000011,
                         OP_JALR = 7'b1100111, OP_ST  = 7'b0100011, OP_BR  = 7'b1100011,
                         OP_LUI  = 7'b0110111, OP_AUI = 7'b0010111, OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5, illegal;
  } bundle_t;

  bundle_t     d, q;
  logic        vld;
  logic [31:0] busy, busy_nxt;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, wr, ill, rd_we;
  logic [31:0] imm;
  logic        byp1, byp2, byp_rd, haz1, haz2, waw, hazard, accept, xfer;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    use1 = 1'b0; use2 = 1'b0; wr = 1'b0; ill = 1'b0; imm = '0;
    case (opc)
      OP_R: begin use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
      OP_I, OP_LD, OP_JALR: begin
        use1 = 1'b1; wr = 1'b1;
        imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_ST: begin
        use1 = 1'b1; use2 = 1'b1;
        imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BR: begin
        use1 = 1'b1; use2 = 1'b1;
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUI: begin wr = 1'b1; imm = {in_instr[31:12], 12'b0}; end
      OP_JAL: begin
        wr = 1'b1;
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ill = 1'b1;
    endcase
  end

  assign rd_we  = wr && (rd != 5'd0);
  assign byp1   = wb_we && (wb_waddr == rs1);
  assign byp2   = wb_we && (wb_waddr == rs2);
  assign byp_rd = wb_we && (wb_waddr == rd);

  // The bundle sitting in the output register has not yet marked its rd busy.
  assign haz1 = use1 && (rs1 != 5'd0) &&
                ((busy[rs1] && !byp1) || (vld && q.rd_we && q.rd == rs1));
  assign haz2 = use2 && (rs2 != 5'd0) &&
                ((busy[rs2] && !byp2) || (vld && q.rd_we && q.rd == rs2));
  assign waw    = rd_we && busy[rd] && !byp_rd;
  assign hazard = in_valid && (haz1 || haz2 || waw);

  assign in_ready = !rst && !flush && !hazard && (!vld || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = vld && out_ready && !flush;

  always_comb begin
    d          = '0;
    d.pc       = in_pc;
    d.rs1_val  = (rs1 == 5'd0) ? 32'd0 : byp1 ? wb_wdata : rf_rd1;
    d.rs2_val  = (rs2 == 5'd0) ? 32'd0 : byp2 ? wb_wdata : rf_rd2;
    d.imm      = imm;
    d.rd       = rd;
    d.rd_we    = rd_we;
    d.opcode   = opc;
    d.funct3   = in_instr[14:12];
    d.funct7b5 = in_instr[30];
    d.illegal  = ill;
  end

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_waddr] = 1'b0;
    if (xfer && q.rd_we) busy_nxt[q.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= d;
    end else if (xfer) begin
      vld <= 1'b0;
    end
  end

  assign out_valid    = vld;
  assign out_pc       = q.pc;
  assign out_rs1_val  = q.rs1_val;
  assign out_rs2_val  = q.rs2_val;
  assign out_imm      = q.imm;
  assign out_rd       = q.rd;
  assign out_rd_we    = q.rd_we;
  assign out_opcode   = q.opcode;
  assign out_funct3   = q.funct3;
  assign out_funct7b5 = q.funct7b5;
  assign out_illegal  = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard/stall/flush/reset sequences.
module tb_decode_stage;
  logic        clk, rst, in_valid, in_ready, wb_we, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_rd1, rf_rd2, wb_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_waddr, out_rd;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic        out_rd_we, out_funct7b5, out_illegal;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        c1;
    logic [31:0] rs1;
    logic        c2;
    logic [31:0] rs2, imm;
    logic [4:0]  rd;
    logic        we;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, ill;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] v);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = v;
    step();
    wb_we = 1'b0;
  endtask

  task automatic do_vec(input int i, input vec_t v);
    in_instr = v.instr; in_pc = v.pc; in_valid = 1'b1; out_ready = 1'b0;
    wb_we = v.wbe; wb_waddr = v.wba; wb_wdata = v.wbd;
    #1 chk($sformatf("v%0d.in_ready", i), in_ready, 1);
    step();
    in_valid = 1'b0; wb_we = 1'b0; in_instr = 32'h0;
    chk($sformatf("v%0d.valid", i), out_valid, 1);
    chk($sformatf("v%0d.pc", i), out_pc, v.pc);
    chk($sformatf("v%0d.imm", i), out_imm, v.imm);
    chk($sformatf("v%0d.rd_we", i), out_rd_we, v.we);
    chk($sformatf("v%0d.opcode", i), out_opcode, v.op);
    chk($sformatf("v%0d.funct3", i), out_funct3, v.f3);
    chk($sformatf("v%0d.funct7b5", i), out_funct7b5, v.f7);
    chk($sformatf("v%0d.illegal", i), out_illegal, v.ill);
    if (v.we) chk($sformatf("v%0d.rd", i), out_rd, v.rd);
    if (v.c1) chk($sformatf("v%0d.rs1", i), out_rs1_val, v.rs1);
    if (v.c2) chk($sformatf("v%0d.rs2", i), out_rs2_val, v.rs2);
    out_ready = 1'b1;
    step();
    chk($sformatf("v%0d.drain", i), out_valid, 0);
    out_ready = 1'b0;
    if (v.we) wb(v.rd, 32'h0);
  endtask

  initial begin
    // instr, pc, wbe, wba, wbd, c1, rs1, c2, rs2, imm, rd, we, op, f3, f7, ill
    vt[0]  = '{32'h0FF00113, 32'h200, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h000000FF, 5'd2,  1'b1, 7'h13, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{32'h123452B7, 32'h204, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h12345000, 5'd5,  1'b1, 7'h37, 3'd5, 1'b0, 1'b0};
    vt[2]  = '{32'hFFFFF317, 32'h208, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFFF000, 5'd6,  1'b1, 7'h17, 3'd7, 1'b1, 1'b0};
    vt[3]  = '{32'hFFDFF0EF, 32'h20C, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFFFFFC, 5'd1,  1'b1, 7'h6F, 3'd7, 1'b1, 1'b0};
    vt[4]  = '{32'h008380E7, 32'h210, 1'b0, 5'd0,  32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0,        32'h00000008, 5'd1,  1'b1, 7'h67, 3'd0, 1'b0, 1'b0};
    vt[5]  = '{32'hFE942C23, 32'h214, 1'b0, 5'd0,  32'h0,        1'b1, 32'h11111111, 1'b1, 32'h22222222, 32'hFFFFFFF8, 5'd24, 1'b0, 7'h23, 3'd2, 1'b1, 1'b0};
    vt[6]  = '{32'hFEB508E3, 32'h218, 1'b0, 5'd0,  32'h0,        1'b1, 32'h11111111, 1'b1, 32'h22222222, 32'hFFFFFFF0, 5'd17, 1'b0, 7'h63, 3'd0, 1'b1, 1'b0};
    vt[7]  = '{32'h0046A603, 32'h21C, 1'b1, 5'd13, 32'hCAFEBABE, 1'b1, 32'hCAFEBABE, 1'b0, 32'h0,        32'h00000004, 5'd12, 1'b1, 7'h03, 3'd2, 1'b0, 1'b0};
    vt[8]  = '{32'h41078733, 32'h220, 1'b1, 5'd16, 32'h0BADF00D, 1'b1, 32'h11111111, 1'b1, 32'h0BADF00D, 32'h00000000, 5'd14, 1'b1, 7'h33, 3'd0, 1'b1, 1'b0};
    vt[9]  = '{32'h00000000, 32'h224, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h00000000, 5'd0,  1'b0, 7'h00, 3'd0, 1'b0, 1'b1};
    vt[10] = '{32'h00100013, 32'h228, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h00000001, 5'd0,  1'b0, 7'h13, 3'd0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    rf_rd1 = 32'h11111111; rf_rd2 = 32'h22222222;
    in_instr = 32'h0FF00113; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
    #2;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.pc", out_pc, 0);
    chk("rst.imm", out_imm, 0);
    chk("rst.rd", out_rd, 0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;

    // ADDI x2 then a RAW on x2 released by same-cycle write-back
    in_instr = 32'h0FF00113; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("s1.rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("s1.valid", out_valid, 1);
    chk("s1.pc", out_pc, 32'h100);
    chk("s1.imm", out_imm, 32'hFF);
    chk("s1.rd", out_rd, 2);
    chk("s1.rd_we", out_rd_we, 1);
    chk("s1.rs1", out_rs1_val, 0);
    step();
    chk("s1.drain", out_valid, 0);
    in_instr = 32'h00001137; in_valid = 1'b1;
    #1 chk("s1.waw", in_ready, 0);
    in_instr = 32'h002101B3;
    #1 chk("s1.raw", in_ready, 0);
    wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'd255;
    #1 chk("s1.byp_rdy", in_ready, 1);
    step();
    in_valid = 1'b0; wb_we = 1'b0;
    chk("s1.add_rs1", out_rs1_val, 32'd255);
    chk("s1.add_rs2", out_rs2_val, 32'd255);
    chk("s1.add_rd", out_rd, 3);
    step();
    in_instr = 32'h000103B3; in_valid = 1'b1;
    #1 chk("s1.x2free", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("s1.x7rs1", out_rs1_val, 32'h11111111);
    step();
    in_instr = 32'h00018433; in_valid = 1'b1;
    #1 chk("s1.x3busy", in_ready, 0);
    in_valid = 1'b0;
    wb(5'd3, 32'h0);
    wb(5'd7, 32'h0);

    // RAW against the bundle in the output register, then against busy
    in_instr = 32'h1FF00213; in_pc = 32'h300; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_instr = 32'h000202B3; in_pc = 32'h304;
    #1 chk("s2.fwd_haz", in_ready, 0);
    step();
    chk("s2.gone", out_valid, 0);
    chk("s2.stall", in_ready, 0);
    step();
    chk("s2.stall2", in_ready, 0);
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'd511;
    #1 chk("s2.rel", in_ready, 1);
    step();
    in_valid = 1'b0; wb_we = 1'b0;
    chk("s2.rs1", out_rs1_val, 32'd511);
    chk("s2.pc", out_pc, 32'h304);
    step();
    wb(5'd5, 32'h0);

    // downstream backpressure
    out_ready = 1'b0;
    in_instr = 32'h00700493; in_pc = 32'h400; in_valid = 1'b1;
    step();
    in_instr = 32'h00300513; in_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("s3.blk%0d", k), in_ready, 0);
      chk($sformatf("s3.pc%0d", k), out_pc, 32'h400);
      chk($sformatf("s3.imm%0d", k), out_imm, 32'd7);
      step();
    end
    out_ready = 1'b1;
    #1 chk("s3.rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("s3.pc", out_pc, 32'h404);
    chk("s3.imm", out_imm, 32'd3);
    chk("s3.rd", out_rd, 10);
    step();
    wb(5'd9, 32'h0);
    wb(5'd10, 32'h0);

    // flush kills the bundle and must not mark x6 busy
    out_ready = 1'b0;
    in_instr = 32'h00100313; in_pc = 32'h500; in_valid = 1'b1;
    step();
    chk("s4.rd", out_rd, 6);
    chk("s4.valid", out_valid, 1);
    in_instr = 32'h00200593; in_pc = 32'h504; out_ready = 1'b1; flush = 1'b1;
    #1 chk("s4.rdy", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("s4.killed", out_valid, 0);
    in_instr = 32'h00030633; in_pc = 32'h508; in_valid = 1'b1;
    #1 chk("s4.x6free", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("s4.pc", out_pc, 32'h508);
    step();
    wb(5'd12, 32'h0);

    for (int i = 0; i < 11; i++) do_vec(i, vt[i]);

    // asynchronous reset mid-stall discards bundle and busy bits
    out_ready = 1'b1;
    in_instr = 32'h00700493; in_pc = 32'h600; in_valid = 1'b1;
    step();
    in_instr = 32'h00300513; in_pc = 32'h604;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("s5.valid", out_valid, 0);
    chk("s5.pc", out_pc, 0);
    chk("s5.rd", out_rd, 0);
    chk("s5.rdy", in_ready, 0);
    step();
    rst = 1'b0;
    in_instr = 32'h000485B3; in_pc = 32'h608; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("s5.x9free", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("s5.loaded", out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode/operand-read pipeline stage of the rv32i core, between fetch and execute. Decodes one instruction per cycle and drives the RegisterFile read addresses. It captures operands with write-back bypass, blocks RAW/WAW hazards with a busy-register scoreboard, and presents a registered, valid/ready-handshaked bundle to execute.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rf_raddr1 / rf_raddr2  out  5  RegisterFile read addresses = in_instr[19:15] / [24:20], combinational, always driven
- rf_rd1 / rf_rd2  in  32  RegisterFile combinational read data
- wb_we, wb_waddr, wb_wdata  in  1/5/32  write-back port, same values driven into RegisterFile we/waddr/wdata
- flush  in  1  execute redirect; kills this stage's contents
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  32; out_rs1_val, out_rs2_val  out  32; out_imm  out  32
- out_rd  out  5; out_rd_we  out  1; out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1; out_illegal  out  1

## Operation
- Opcode classes and source use: OP 0110011 (rs1, rs2, rd); OP-IMM 0010011, LOAD 0000011, JALR 1100111 (rs1, rd); STORE 0100011, BRANCH 1100011 (rs1, rs2, no rd); LUI 0110111, AUIPC 0010111, JAL 1101111 (rd only). Any other opcode: out_illegal=1, no sources, out_rd_we=0.
- out_rd_we = class writes rd AND rd != 0.
- Immediate: I/S/B/U/J formats per RV32I, sign-extended from instr[31]; B and J bit 0 = 0; U low 12 bits = 0; R-type and illegal give imm 0.
- Operand value per source: if index == 0, value is 0. Else if wb_we and wb_waddr == index, value is wb_wdata (bypass). Else value is rf_rd1/rf_rd2. Unused sources are captured as-is; they are don't-care.
- Scoreboard: busy[31:1], with busy[0] hardwired 0.
  - Set bit out_rd on a downstream transfer (out_valid && out_ready && !flush) with out_rd_we=1.
  - Clear bit wb_waddr when wb_we=1.
  - Set and clear of the same bit in one cycle: set wins.
- Hazard, for a valid in_instr:
  - Any used source s != 0 with busy[s]=1 and not bypassed this cycle is a hazard.
  - A used source s that equals out_rd while out_valid && out_rd_we is a hazard.
  - The instruction's own rd with busy[rd]=1 and not cleared this cycle is a hazard (WAW).
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Output register:
  - On in_valid && in_ready, load all out_* fields and set out_valid=1.
  - Else, on a downstream transfer, out_valid=0.
  - Else hold all fields stable.
- Flush has priority: next cycle out_valid=0, no downstream transfer counts, busy is not set for the killed bundle, and no input is accepted. Busy bits from older instructions remain; they clear via write-back.

## Timing
- Reset (async): out_valid=0, all out_* data 0, busy all 0; in_ready=0 while rst=1.
- Latency: in handshake at edge N gives out_valid=1 and the bundle after edge N; one instruction per cycle when there are no hazards and out_ready=1.
- A RAW stall releases in the cycle wb_we matches the source (bypass), so it costs zero extra cycles beyond write-back.
- out_* stays stable while out_valid && !out_ready.
- Reset asserted mid-stall or mid-transfer discards all state immediately.

## Test plan
- Reset, then ADDI x2,x0,255 (0x0FF00113) at pc 0x100 with out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_imm=0x000000FF, out_rd=2, out_rd_we=1, out_rs1_val=0; busy[2]=1 after the transfer.
- With busy[2]=1, present ADD x3,x2,x2 (0x002101B3) while wb_we=1, wb_waddr=2, wb_wdata=255 -> accepted the same cycle; out_rs1_val=out_rs2_val=255; busy[2] cleared, busy[3] set after the transfer.
- Issue ADDI x4,x0,511 (0x1FF00213), then ADD x5,x4,x0 (0x000202B3) -> in_ready=0 until write-back of x4 (wb_wdata=511) arrives -> then accepted with out_rs1_val=511.
- Hold out_ready=0 for 3 cycles with a valid bundle -> out_* unchanged, in_ready=0; raise out_ready -> the next instruction loads on the following edge.
- Assert flush with out_valid=1, out_rd=6, out_ready=1 -> out_valid=0 next cycle, busy[6] stays 0, in_instr is not consumed.
- Present 0x00000000 -> out_illegal=1, out_rd_we=0. Present ADDI x0,x0,1 (0x00100013) -> out_rd_we=0 and busy unchanged.
